// File: rtl/pll_fbdiv_if.sv
// pll_fbdiv_if -- control/status bundle for the PLL feedback divider.
//
// Signals:
//   en    enable for the divider (driven by the PLL controller)
//   div   requested divide ratio N
//   load  one-cycle strobe that captures div as the pending ratio
//   out   divided clock towards the PFD (registered in the divider)
//   tc    terminal-count pulse, one cycle per output period
//   busy  a captured ratio is waiting for the next period boundary
//
// Modports:
//   master  the controller side: drives en/div/load, observes status
//   slave   the divider side: samples en/div/load, drives out/tc/busy
interface pll_fbdiv_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div;
    logic             load;
    logic             out;
    logic             tc;
    logic             busy;

    modport master (
        output en,
        output div,
        output load,
        input  out,
        input  tc,
        input  busy
    );

    modport slave (
        input  en,
        input  div,
        input  load,
        output out,
        output tc,
        output busy
    );
endinterface

// File: rtl/pll_fbdiv.sv
// pll_fbdiv -- programmable integer-N feedback divider.
//
// Runs on the VCO clock and divides it by N to produce the feedback clock
// for the phase-frequency detector. The output is high for ceil(N/2)
// cycles and low for floor(N/2) cycles of every N-cycle period. New
// ratios are captured into a pending register and only promoted to the
// active ratio at a period boundary (or straight away while disabled), so
// the PFD never sees a truncated period.
//
// Ports:
//   clk   VCO clock, rising-edge
//   r     synchronous active-high reset
//   vdd   supply pin, no logic function
//   vss   supply pin, no logic function
//   bus   pll_fbdiv_if.slave: en, div, load in; out, tc, busy out
//
// Parameters:
//   WIDTH    width of the ratio and of the period counter
//   DEF_DIV  ratio used after reset, 2 .. 2**WIDTH-1
module pll_fbdiv #(
    parameter int WIDTH   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic        clk,
    input  logic        r,
    input  logic        vdd,
    input  logic        vss,
    pll_fbdiv_if.slave  bus
);

    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] n_pend;
    logic             out_q;
    logic             tc_q;
    logic             busy_q;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] last;
    logic             at_last;
    logic [WIDTH-1:0] div_clamped;

    // Supply pins exist only to match the analog macro footprint.
    logic unused_supply;
    assign unused_supply = vdd ^ vss;

    // ceil(N/2) without needing an extra bit: N - floor(N/2).
    assign hi      = n_act - (n_act >> 1);
    // n_act is never below 2, so this cannot underflow.
    assign last    = n_act - ONE;
    assign at_last = (cnt == last);

    // Ratios 0 and 1 cannot be produced by this counter; treat them as 2.
    assign div_clamped = (bus.div < TWO) ? TWO : bus.div;

    always_ff @(posedge clk) begin
        if (r) begin
            cnt    <= '0;
            n_act  <= DEF_N;
            n_pend <= DEF_N;
            out_q  <= 1'b0;
            tc_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            if (bus.en) begin
                cnt   <= at_last ? '0 : cnt + ONE;
                out_q <= (cnt < hi);
                tc_q  <= at_last;
                // The period that is finishing keeps the old ratio; the
                // next one starts from cnt=0 with the new ratio.
                if (busy_q && at_last) begin
                    n_act  <= n_pend;
                    busy_q <= 1'b0;
                end
            end else begin
                cnt   <= '0;
                out_q <= 1'b0;
                tc_q  <= 1'b0;
                // Nothing is running, so there is no period to protect.
                if (busy_q) begin
                    n_act  <= n_pend;
                    busy_q <= 1'b0;
                end
            end

            // Placed last so a load on an apply edge keeps busy set: the
            // previously pending ratio is applied and the new one waits.
            if (bus.load) begin
                n_pend <= div_clamped;
                busy_q <= 1'b1;
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.tc   = tc_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_pll_fbdiv.sv
// Directed testbench for pll_fbdiv with hand-computed expected waveforms.
module tb_pll_fbdiv;

    logic clk;
    logic r;
    logic vdd;
    logic vss;

    int total;
    int bad;

    pll_fbdiv_if #(.WIDTH(8)) bus ();

    pll_fbdiv #(
        .WIDTH   (8),
        .DEF_DIV (4)
    ) dut (
        .clk (clk),
        .r   (r),
        .vdd (vdd),
        .vss (vss),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One tick per bit, MSB first; compares {out,tc,busy} each cycle.
    task automatic pat(input string tag, input int n, input logic [63:0] outs,
                       input logic [63:0] tcs, input logic e_busy);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, {5'b0, bus.out, bus.tc, bus.busy},
                {5'b0, outs[n-1-i], tcs[n-1-i], e_busy});
        end
    endtask

    function automatic logic [7:0] st();
        return {5'b0, bus.out, bus.tc, bus.busy};
    endfunction

    initial begin
        total    = 0;
        bad      = 0;
        vdd      = 1'b1;
        vss      = 1'b0;
        r        = 1'b1;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.div  = 8'd0;

        // reset and default ratio 4
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset", st(), 8'b000);
        end
        r      = 1'b0;
        bus.en = 1'b1;
        pat("def_div4", 8, 64'b11001100, 64'b00010001, 1'b0);

        // odd ratio loaded while disabled
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.div  = 8'd5;
        tick();
        chk("odd_load", st(), 8'b001);
        bus.load = 1'b0;
        tick();
        chk("odd_apply", st(), 8'b000);
        bus.en = 1'b1;
        pat("odd5", 10, 64'b1110011100, 64'b0000100001, 1'b0);

        // back to N=4, then change to 3 at cnt=1
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.div  = 8'd4;
        tick();
        bus.load = 1'b0;
        tick();
        chk("set4", st(), 8'b000);
        bus.en = 1'b1;
        tick();
        chk("mid_c0", st(), 8'b100);
        bus.load = 1'b1;
        bus.div  = 8'd3;
        tick();
        chk("mid_c1", st(), 8'b101);
        bus.load = 1'b0;
        tick();
        chk("mid_c2", st(), 8'b001);
        tick();
        chk("mid_c3", st(), 8'b010);
        pat("mid_n3", 6, 64'b110110, 64'b001001, 1'b0);

        // clamp and last-wins inside one N=5 period
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.div  = 8'd5;
        tick();
        bus.load = 1'b0;
        tick();
        bus.en   = 1'b1;
        bus.load = 1'b1;
        bus.div  = 8'd0;
        tick();
        chk("clamp_e1", st(), 8'b101);
        bus.div = 8'd1;
        tick();
        chk("clamp_e2", st(), 8'b101);
        bus.div = 8'd7;
        tick();
        chk("clamp_e3", st(), 8'b101);
        bus.load = 1'b0;
        tick();
        chk("clamp_e4", st(), 8'b001);
        tick();
        chk("clamp_e5", st(), 8'b010);
        pat("clamp_n7", 14, 64'b11110001111000, 64'b00000010000001, 1'b0);

        // div=1 alone clamps to 2
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.div  = 8'd1;
        tick();
        chk("div1_load", st(), 8'b001);
        bus.load = 1'b0;
        tick();
        chk("div1_apply", st(), 8'b000);
        bus.en = 1'b1;
        pat("div1", 6, 64'b101010, 64'b010101, 1'b0);

        // load coinciding with a boundary waits one more period
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.div  = 8'd4;
        tick();
        bus.load = 1'b0;
        tick();
        bus.en = 1'b1;
        pat("bnd_pre", 3, 64'b110, 64'b000, 1'b0);
        bus.load = 1'b1;
        bus.div  = 8'd6;
        tick();
        chk("bnd_edge", st(), 8'b011);
        bus.load = 1'b0;
        pat("bnd_old4", 3, 64'b110, 64'b000, 1'b1);
        tick();
        chk("bnd_apply", st(), 8'b010);
        pat("bnd_n6", 6, 64'b111000, 64'b000001, 1'b0);

        // reset while out=1 and busy=1
        bus.load = 1'b1;
        bus.div  = 8'd9;
        tick();
        chk("rst_pre", st(), 8'b101);
        bus.load = 1'b0;
        r        = 1'b1;
        tick();
        chk("rst_hit", st(), 8'b000);
        chk("rst_cnt", dut.cnt, 8'd0);
        r = 1'b0;
        pat("rst_def", 8, 64'b11001100, 64'b00010001, 1'b0);

        // drop and restore enable mid-period
        tick();
        chk("en_run", st(), 8'b100);
        bus.en = 1'b0;
        tick();
        chk("en_off", st(), 8'b000);
        chk("en_off_cnt", dut.cnt, 8'd0);
        bus.en = 1'b1;
        pat("en_on", 4, 64'b1100, 64'b0001, 1'b0);

        // largest ratio 255: 128 high, 127 low, tc on the last cycle, wrap
        bus.en   = 1'b0;
        bus.load = 1'b1;
        bus.div  = 8'd255;
        tick();
        bus.load = 1'b0;
        tick();
        chk("max_apply", st(), 8'b000);
        bus.en = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick();
            chk("max_n255", st(), {5'b0, (i < 128), (i == 254), 1'b0});
        end
        tick();
        chk("max_wrap", st(), 8'b100);
        chk("max_wrap_cnt", dut.cnt, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
